// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared memory bus between fetch (I) and data (D) ports.
// D wins by default; a streak counter forces I through under sustained D load.
module mem_port_arbiter #(
  parameter int AW           = 32,
  parameter int DW           = 32,
  parameter int MAX_D_CONSEC = 4,
  parameter int TIMEOUT      = 255
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_req,
  input  logic [AW-1:0]   i_addr,
  output logic            i_ack,
  output logic            i_err,
  output logic [DW-1:0]   i_rdata,
  input  logic            d_req,
  input  logic            d_we,
  input  logic [AW-1:0]   d_addr,
  input  logic [DW-1:0]   d_wdata,
  input  logic [DW/8-1:0] d_be,
  output logic            d_ack,
  output logic            d_err,
  output logic [DW-1:0]   d_rdata,
  output logic            mem_req,
  output logic            mem_we,
  output logic [AW-1:0]   mem_addr,
  output logic [DW-1:0]   mem_wdata,
  output logic [DW/8-1:0] mem_be,
  input  logic            mem_ready,
  input  logic [DW-1:0]   mem_rdata
);

  localparam int BW = DW / 8;
  localparam logic [7:0] MAXC = 8'(MAX_D_CONSEC);
  localparam logic [7:0] TLAST = 8'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } state_e;

  state_e          state_q, state_d;
  logic            we_q, we_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [BW-1:0]   be_q, be_d;
  logic [7:0]      streak_q, streak_d;
  logic [7:0]      tmo_q, tmo_d;
  logic            i_ack_q, i_ack_d;
  logic            i_err_q, i_err_d;
  logic [DW-1:0]   i_rdata_q, i_rdata_d;
  logic            d_ack_q, d_ack_d;
  logic            d_err_q, d_err_d;
  logic [DW-1:0]   d_rdata_q, d_rdata_d;
  logic            i_elig, d_elig, tmo_hit;

  always_comb begin
    state_d   = state_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    be_d      = be_q;
    streak_d  = streak_q;
    tmo_d     = tmo_q;
    i_ack_d   = 1'b0;
    i_err_d   = i_err_q;
    i_rdata_d = i_rdata_q;
    d_ack_d   = 1'b0;
    d_err_d   = d_err_q;
    d_rdata_d = d_rdata_q;
    // A request whose ack is visible now is already served.
    i_elig    = i_req & ~i_ack_q;
    d_elig    = d_req & ~d_ack_q;
    tmo_hit   = (TIMEOUT != 0) && (tmo_q == TLAST);
    unique case (state_q)
      IDLE: begin
        if (d_elig && (!i_elig || streak_q < MAXC)) begin
          state_d = BUSY_D;
          we_d    = d_we;
          addr_d  = d_addr;
          wdata_d = d_wdata;
          be_d    = d_be;
          tmo_d   = 8'd0;
          if (!i_elig) streak_d = 8'd0;
          else if (streak_q != 8'hFF) streak_d = streak_q + 8'd1;
        end else if (i_elig) begin
          state_d  = BUSY_I;
          we_d     = 1'b0;
          addr_d   = i_addr;
          wdata_d  = '0;
          be_d     = '1;
          tmo_d    = 8'd0;
          streak_d = 8'd0;
        end
      end
      BUSY_I, BUSY_D: begin
        if (mem_ready || tmo_hit) begin
          state_d = IDLE;
          if (state_q == BUSY_I) begin
            i_ack_d   = 1'b1;
            i_err_d   = ~mem_ready;
            i_rdata_d = mem_ready ? mem_rdata : '0;
          end else begin
            d_ack_d   = 1'b1;
            d_err_d   = ~mem_ready;
            d_rdata_d = mem_ready ? mem_rdata : '0;
          end
        end else if (tmo_q != 8'hFF) begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      streak_q  <= 8'd0;
      tmo_q     <= 8'd0;
      i_ack_q   <= 1'b0;
      i_err_q   <= 1'b0;
      i_rdata_q <= '0;
      d_ack_q   <= 1'b0;
      d_err_q   <= 1'b0;
      d_rdata_q <= '0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      be_q      <= be_d;
      streak_q  <= streak_d;
      tmo_q     <= tmo_d;
      i_ack_q   <= i_ack_d;
      i_err_q   <= i_err_d;
      i_rdata_q <= i_rdata_d;
      d_ack_q   <= d_ack_d;
      d_err_q   <= d_err_d;
      d_rdata_q <= d_rdata_d;
    end
  end

  assign mem_req   = (state_q != IDLE);
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign mem_be    = be_q;
  assign i_ack     = i_ack_q;
  assign i_err     = i_err_q;
  assign i_rdata   = i_rdata_q;
  assign d_ack     = d_ack_q;
  assign d_err     = d_err_q;
  assign d_rdata   = d_rdata_q;

endmodule
